// File: rtl/eqed_sig_checker.sv
// -----------------------------------------------------------------------------
// eqed_sig_checker
// Observation-side companion to the E-QED bit-flip injector. A bundle of
// monitored 1-bit signals is folded into a MISR signature over a fixed
// window of WINDOW cycles. The signature is then compared once against a
// golden value. The pass/fail verdict is held until the checker is re-armed.
//
// Ports:
//   clk      in   rising-edge clock
//   rst      in   asynchronous active-low reset
//   start    in   arm and begin a capture (ignored while busy)
//   abort    in   synchronous return to IDLE, has priority over start
//   din      in   [DATA_W-1:0] monitored signals, din[0] feeds the feedback bit
//   exp_sig  in   [SIG_W-1:0]  golden signature, sampled in CHECK only
//   busy     out  high in CAPTURE or CHECK
//   done     out  high in DONE
//   pass     out  verdict, valid while done
//   fail     out  verdict, valid while done
//   sig      out  [SIG_W-1:0]  live signature register
//   win_cnt  out  [CNT_W-1:0]  compressions performed in the current capture
// -----------------------------------------------------------------------------
module eqed_sig_checker #(
  parameter int               DATA_W = 3,
  parameter int               SIG_W  = 6,
  parameter int               TAP    = 4,
  parameter logic [SIG_W-1:0] SEED   = 6'b000001,
  parameter int               WINDOW = 5,
  parameter int               CNT_W  = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic [DATA_W-1:0] din,
  input  logic [SIG_W-1:0]  exp_sig,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic              fail,
  output logic [SIG_W-1:0]  sig,
  output logic [CNT_W-1:0]  win_cnt
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CAPTURE = 2'd1,
    ST_CHECK   = 2'd2,
    ST_DONE    = 2'd3
  } state_t;

  // The counter value seen on the edge that performs the final compression.
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WINDOW - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};

  // One MISR step. Every bit is computed from the old signature. Input bits
  // beyond DATA_W are treated as zero, so the upper stages shift only.
  function automatic logic [SIG_W-1:0] misr_step(
    input logic [SIG_W-1:0]  s,
    input logic [DATA_W-1:0] d
  );
    logic [SIG_W-1:0] dx;
    logic [SIG_W-1:0] n;
    dx = {SIG_W{1'b0}};
    dx[DATA_W-1:0] = d;
    n = {SIG_W{1'b0}};
    n[0] = s[SIG_W-1] ^ s[TAP] ^ dx[0];
    for (int k = 1; k < SIG_W; k++) begin
      n[k] = s[k-1] ^ dx[k];
    end
    return n;
  endfunction

  state_t           state_r, state_nxt_s;
  logic [SIG_W-1:0] sig_r, sig_nxt_s;
  logic [CNT_W-1:0] cnt_r, cnt_nxt_s;
  logic             pass_r, pass_nxt_s;
  logic             fail_r, fail_nxt_s;
  logic             busy_r, busy_nxt_s;
  logic             done_r, done_nxt_s;

  // Next-state, signature, counter and verdict logic.
  always_comb begin
    state_nxt_s = state_r;
    sig_nxt_s   = sig_r;
    cnt_nxt_s   = cnt_r;
    pass_nxt_s  = pass_r;
    fail_nxt_s  = fail_r;
    if (abort) begin
      state_nxt_s = ST_IDLE;
      sig_nxt_s   = SEED;
      cnt_nxt_s   = CNT_ZERO;
      pass_nxt_s  = 1'b0;
      fail_nxt_s  = 1'b0;
    end else begin
      case (state_r)
        ST_IDLE, ST_DONE: begin
          // Arming from DONE reseeds and clears the old verdict on the same edge.
          if (start) begin
            state_nxt_s = ST_CAPTURE;
            sig_nxt_s   = SEED;
            cnt_nxt_s   = CNT_ZERO;
            pass_nxt_s  = 1'b0;
            fail_nxt_s  = 1'b0;
          end else begin
            state_nxt_s = state_r;
          end
        end
        ST_CAPTURE: begin
          sig_nxt_s = misr_step(sig_r, din);
          cnt_nxt_s = cnt_r + CNT_ONE;
          if (cnt_r == LAST_CNT) begin
            state_nxt_s = ST_CHECK;
          end else begin
            state_nxt_s = ST_CAPTURE;
          end
        end
        ST_CHECK: begin
          pass_nxt_s  = (sig_r == exp_sig);
          fail_nxt_s  = (sig_r != exp_sig);
          state_nxt_s = ST_DONE;
        end
        default: begin
          state_nxt_s = ST_IDLE;
          sig_nxt_s   = SEED;
          cnt_nxt_s   = CNT_ZERO;
          pass_nxt_s  = 1'b0;
          fail_nxt_s  = 1'b0;
        end
      endcase
    end
    // Status flags are decoded from the next state so they register with it.
    busy_nxt_s = (state_nxt_s == ST_CAPTURE) || (state_nxt_s == ST_CHECK);
    done_nxt_s = (state_nxt_s == ST_DONE);
  end

  // State and output registers with asynchronous reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= ST_IDLE;
      sig_r   <= SEED;
      cnt_r   <= CNT_ZERO;
      pass_r  <= 1'b0;
      fail_r  <= 1'b0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      sig_r   <= sig_nxt_s;
      cnt_r   <= cnt_nxt_s;
      pass_r  <= pass_nxt_s;
      fail_r  <= fail_nxt_s;
      busy_r  <= busy_nxt_s;
      done_r  <= done_nxt_s;
    end
  end

  assign busy    = busy_r;
  assign done    = done_r;
  assign pass    = pass_r;
  assign fail    = fail_r;
  assign sig     = sig_r;
  assign win_cnt = cnt_r;

endmodule

// File: tb/tb_eqed_sig_checker.sv
// Testbench for eqed_sig_checker: a WINDOW=5 instance driven with random
// captures and checked through a scoreboard, plus a WINDOW=2 instance with
// directed vectors.
module tb_eqed_sig_checker;

  localparam int         WIN    = 5;
  localparam logic [5:0] SEED_V = 6'b000001;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       start, abort;
  logic [2:0] din;
  logic [5:0] exp_sig;
  logic       busy, done, pass, fail;
  logic [5:0] sig;
  logic [9:0] win_cnt;

  logic       start2;
  logic [2:0] din2;
  logic [5:0] exp2;
  logic       busy2, done2, pass2, fail2;
  logic [5:0] sig2;
  logic [9:0] win_cnt2;

  eqed_sig_checker dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .din(din),
    .exp_sig(exp_sig), .busy(busy), .done(done), .pass(pass), .fail(fail),
    .sig(sig), .win_cnt(win_cnt)
  );

  eqed_sig_checker #(.WINDOW(2)) dut2 (
    .clk(clk), .rst(rst), .start(start2), .abort(1'b0), .din(din2),
    .exp_sig(exp2), .busy(busy2), .done(done2), .pass(pass2), .fail(fail2),
    .sig(sig2), .win_cnt(win_cnt2)
  );

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [5:0] sig;
    logic       pass;
    logic       fail;
    int         cyc;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;
  logic done_q = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference MISR: shift the whole word left, insert the feedback bit,
  // then XOR the input word in.
  function automatic logic [5:0] model_step(input logic [5:0] s, input logic [2:0] d);
    logic       fb;
    logic [5:0] sh;
    fb = s[5] ^ s[4];
    sh = s << 1;
    sh[0] = fb;
    return sh ^ {3'b000, d};
  endfunction

  // Monitor: invariants every cycle, scoreboard compare when done rises.
  always @(negedge clk) begin
    chk("busy_done_excl", 32'(busy & done), 32'd0);
    if (!done) chk("verdict_idle", 32'({pass, fail}), 32'd0);
    if (done && !done_q) begin
      if (sb_q.size() == 0) begin
        chk("sb_unexpected_done", 32'(sb_q.size()), 32'd1);
      end else begin
        mon_e = sb_q.pop_front();
        chk("sb_sig", 32'(sig), 32'(mon_e.sig));
        chk("sb_pass", 32'(pass), 32'(mon_e.pass));
        chk("sb_fail", 32'(fail), 32'(mon_e.fail));
        chk("sb_win_cnt", 32'(win_cnt), 32'(WIN));
        chk("sb_latency", 32'(cyc), 32'(mon_e.cyc));
      end
    end
    done_q <= done;
  end

  // One capture on the WINDOW=5 instance.
  // mode: 0 golden matches, 1 single din bit flipped, 2 random golden.
  task automatic capture(input int mode, input bit start_mid, input bit do_abort, input bit do_rst);
    logic [2:0] d[WIN];
    logic [5:0] golden, model, e;
    int         n0;
    bool_dummy: begin end
    for (int i = 0; i < WIN; i++) d[i] = 3'($urandom_range(0, 7));
    golden = SEED_V;
    for (int i = 0; i < WIN; i++) golden = model_step(golden, d[i]);
    if (mode == 1) begin
      int idx, b;
      idx = $urandom_range(0, WIN - 1);
      b   = $urandom_range(0, 2);
      d[idx][b] = ~d[idx][b];
    end
    e = (mode == 2) ? 6'($urandom_range(0, 63)) : golden;

    @(posedge clk); #1;
    start   = 1'b1;
    exp_sig = e;
    din     = 3'($urandom_range(0, 7));
    @(posedge clk); #1;
    n0    = cyc;
    start = 1'b0;
    chk("start_sig", 32'(sig), 32'(SEED_V));
    chk("start_cnt", 32'(win_cnt), 32'd0);
    chk("start_verdict", 32'({pass, fail, done}), 32'd0);
    chk("start_busy", 32'(busy), 32'd1);

    model = SEED_V;
    for (int i = 0; i < WIN; i++) model = model_step(model, d[i]);
    if (!do_abort && !do_rst) begin
      sb_q.push_back('{sig: model, pass: (model == e), fail: (model != e), cyc: n0 + WIN + 1});
    end

    model = SEED_V;
    for (int i = 0; i < WIN; i++) begin
      din   = d[i];
      start = start_mid && (i == 2);
      @(posedge clk); #1;
      start = 1'b0;
      model = model_step(model, d[i]);
      chk("run_cnt", 32'(win_cnt), 32'(i + 1));
      chk("run_sig", 32'(sig), 32'(model));
      if (do_abort && i == 2) begin
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        chk("abort_sig", 32'(sig), 32'(SEED_V));
        chk("abort_cnt", 32'(win_cnt), 32'd0);
        chk("abort_flags", 32'({busy, done, pass, fail}), 32'd0);
        return;
      end
      if (do_rst && i == 1) begin
        #1 rst = 1'b0;
        #1;
        chk("arst_sig", 32'(sig), 32'(SEED_V));
        chk("arst_cnt", 32'(win_cnt), 32'd0);
        chk("arst_flags", 32'({busy, done, pass, fail}), 32'd0);
        #1 rst = 1'b1;
        return;
      end
    end

    for (int t = 0; t < 20 && !done; t++) begin
      din = 3'($urandom_range(0, 7));
      @(posedge clk); #1;
    end
    if (!done) begin
      chk("done_timeout", 32'(done), 32'd1);
      if (sb_q.size() != 0) void'(sb_q.pop_front());
      return;
    end
    for (int t = 0; t < 2; t++) begin
      din = 3'($urandom_range(0, 7));
      @(posedge clk); #1;
      chk("hold_sig", 32'(sig), 32'(model));
      chk("hold_cnt", 32'(win_cnt), 32'(WIN));
      chk("hold_done", 32'(done), 32'd1);
    end
  endtask

  // Directed capture on the WINDOW=2 instance with a held din value.
  task automatic dut2_run(input logic [2:0] dval, input logic [5:0] s1, input logic [5:0] s2,
                          input logic [5:0] e, input logic exp_pass);
    @(posedge clk); #1;
    start2 = 1'b1;
    exp2   = e;
    @(posedge clk); #1;
    start2 = 1'b0;
    din2   = dval;
    chk("w2_seed", 32'(sig2), 32'(SEED_V));
    @(posedge clk); #1;
    chk("w2_sig1", 32'(sig2), 32'(s1));
    @(posedge clk); #1;
    chk("w2_sig2", 32'(sig2), 32'(s2));
    chk("w2_busy", 32'({busy2, done2}), 32'b10);
    @(posedge clk); #1;
    chk("w2_done", 32'({busy2, done2}), 32'b01);
    chk("w2_pass", 32'(pass2), 32'(exp_pass));
    chk("w2_fail", 32'(fail2), 32'(!exp_pass));
    @(posedge clk); #1;
    chk("w2_hold_sig", 32'(sig2), 32'(s2));
    chk("w2_hold_cnt", 32'(win_cnt2), 32'd2);
  endtask

  initial begin
    rst = 1'b0; start = 1'b0; abort = 1'b0; din = 3'b000; exp_sig = 6'b000000;
    start2 = 1'b0; din2 = 3'b000; exp2 = 6'b000000;
    #12;
    chk("reset_sig", 32'(sig), 32'(SEED_V));
    chk("reset_cnt", 32'(win_cnt), 32'd0);
    chk("reset_flags", 32'({busy, done, pass, fail}), 32'd0);
    #1 rst = 1'b1;

    dut2_run(3'b000, 6'b000010, 6'b000100, 6'b000100, 1'b1);
    dut2_run(3'b001, 6'b000011, 6'b000111, 6'b000100, 1'b0);

    for (int i = 0; i < 3; i++) capture(0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) capture(1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) capture(2, 1'b0, 1'b0, 1'b0);
    capture(0, 1'b1, 1'b0, 1'b0);
    capture(0, 1'b0, 1'b1, 1'b0);
    capture(0, 1'b0, 1'b0, 1'b0);
    capture(1, 1'b0, 1'b0, 1'b1);
    capture(0, 1'b0, 1'b0, 1'b0);

    repeat (3) @(posedge clk);
    #1;
    chk("sb_drained", 32'(sb_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/eqed_sig_checker.md
Name: eqed_sig_checker

Overview:
- Observation-side counterpart to the E-QED single-cycle bit-flip injector.
- Compresses a bundle of monitored module outputs into a MISR signature over a fixed capture window, then compares it against an expected golden signature.
- Reports pass/fail and holds the result until re-armed.
- Sits beside the injection wrapper. One instance per monitored interface (design-module outputs, neighbouring-module outputs).

Parameters:
- DATA_W, 3, number of monitored 1-bit signals compressed per cycle (1..SIG_W)
- SIG_W, 6, signature width (>=3)
- TAP, 4, second feedback tap index into the signature (0..SIG_W-2)
- SEED, 6'b000001, signature value loaded on start and on reset
- WINDOW, 5, number of compression cycles per capture (1..2^CNT_W-1)
- CNT_W, 10, width of the window cycle counter

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-low reset (0 = reset)
- start  input  1  arm and begin a capture (single-cycle pulse; level tolerated)
- abort  input  1  synchronous return to IDLE; beats start
- din  input  DATA_W  monitored signals, din[0] drives the feedback bit
- exp_sig  input  SIG_W  golden signature; sampled only in CHECK
- busy  output  1  high in CAPTURE or CHECK
- done  output  1  high in DONE
- pass  output  1  valid when done; sig == exp_sig
- fail  output  1  valid when done; sig != exp_sig
- sig  output  SIG_W  live signature register
- win_cnt  output  CNT_W  compressions performed in current capture

Behaviour:
- States: IDLE, CAPTURE, CHECK, DONE. Encoding is free.
- Reset (rst=0, asynchronous):
  - state = IDLE
  - sig = SEED
  - win_cnt = 0
  - busy = done = pass = fail = 0
- IDLE:
  - start=1 -> CAPTURE; same edge loads sig = SEED and win_cnt = 0.
- CAPTURE: each edge compresses din into sig (all bits simultaneously, from the old sig):
  - sig'[0] = sig[SIG_W-1] ^ sig[TAP] ^ din[0]
  - sig'[k] = sig[k-1] ^ din[k] for 1 <= k < DATA_W
  - sig'[k] = sig[k-1] for k >= DATA_W
  - win_cnt increments each compression.
  - On the edge performing compression number WINDOW -> CHECK.
- CHECK (one cycle):
  - No compression.
  - Next edge latches pass = (sig == exp_sig), fail = !pass, and goes to DONE.
- DONE:
  - sig, win_cnt, pass and fail hold.
  - start=1 -> CAPTURE (reseed, clear pass/fail same edge).
- Latency: with the start edge as E0, din is sampled on E1..E_WINDOW and done rises after E_(WINDOW+1).
- Status outputs are registered; done and busy are never high together.
- start in CAPTURE or CHECK is ignored; there is no restart mid-window.
- abort=1 in any state -> IDLE at the next edge, with sig = SEED, win_cnt = 0, and pass/fail/done cleared. abort has priority over start.
- rst asserted mid-capture forces the reset values immediately. The first start after rst rises begins a fresh capture.
- win_cnt saturates conceptually at WINDOW and never wraps.
- pass and fail are both 0 whenever done = 0.

Test Plan:
- Reset, start, din=0 for the window, WINDOW=2 (SEED 000001) -> sig 000010 then 000100; with exp_sig=000100, done after E3 with pass=1, fail=0.
- WINDOW=2, din=3'b001 held -> sig 000011 then 000111; with exp_sig=000100, done with fail=1, pass=0, and sig=000111 holding.
- Default WINDOW=5: start, then din stream compared against an independent MISR model -> pass=1 when exp_sig equals the model value. Flipping a single din bit on any one cycle -> fail=1.
- start pulsed again during CAPTURE at win_cnt=2 -> ignored; done still after E6, win_cnt=5.
- abort at win_cnt=3 -> IDLE next edge with sig=000001, win_cnt=0, busy=0, done=0. A later start runs a full clean window.
- rst driven low asynchronously mid-window (between edges) -> outputs reach their reset values without a clock edge. In DONE, start reseeds and clears pass/fail on the same edge.
